// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Shift-add multiply, restoring divide, W iterations per operation.
module muldiv_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] N1,
    input  logic [W-1:0] N2,
    input  logic         abort,
    output logic         ready,
    output logic         busy,
    output logic         result_valid,
    output logic [W-1:0] out,
    output logic         flag
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic            r_neg1;
    logic            r_neg2;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;

    logic            w_s1;
    logic            w_s2;
    logic            w_neg1;
    logic            w_neg2;
    logic [W-1:0]    w_mag1;
    logic [W-1:0]    w_mag2;
    logic            w_dz;
    logic            w_ovf;
    logic [W-1:0]    w_byp;
    logic [W:0]      w_sum;
    logic            w_ge;
    logic [W-1:0]    w_diff;
    logic [W-1:0]    w_hi_n;
    logic [W-1:0]    w_lo_n;
    logic [2*W-1:0]  w_prod;
    logic [W-1:0]    w_quo;
    logic [W-1:0]    w_rem;
    logic [W-1:0]    w_res;

    // Operand sign/magnitude split and divide bypass detection at accept
    always_comb begin
        w_s1   = (op == 3'b001) || (op == 3'b010) ||
                 (op == 3'b100) || (op == 3'b110);
        w_s2   = (op == 3'b001) || (op == 3'b100) ||
                 (op == 3'b110);
        w_neg1 = w_s1 & N1[W-1];
        w_neg2 = w_s2 & N2[W-1];
        w_mag1 = w_neg1 ? (~N1 + W'(1)) : N1;
        w_mag2 = w_neg2 ? (~N2 + W'(1)) : N2;
        w_dz   = op[2] && (N2 == '0);
        w_ovf  = ((op == 3'b100) || (op == 3'b110)) &&
                 (N1 == {1'b1, {(W-1){1'b0}}}) &&
                 (N2 == '1);
        w_byp  = '0;
        if (w_dz)
            w_byp = op[1] ? N1 : '1;
        else if (w_ovf)
            w_byp = op[1] ? '0 : N1;
    end

    // One multiply or divide step on the {hi, lo} pair
    always_comb begin
        w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
        w_ge   = {r_hi, r_lo[W-1]} >= {1'b0, r_b};
        w_diff = {r_hi[W-2:0], r_lo[W-1]} - r_b;
        w_hi_n = r_hi;
        w_lo_n = r_lo;
        if (r_op[2]) begin
            w_hi_n = w_ge ? w_diff : {r_hi[W-2:0], r_lo[W-1]};
            w_lo_n = {r_lo[W-2:0], w_ge};
        end else begin
            {w_hi_n, w_lo_n} = {w_sum, r_lo[W-1:1]};
        end
    end

    // Sign correction and result select from the final step
    always_comb begin
        w_prod = {w_hi_n, w_lo_n};
        if (r_neg1 ^ r_neg2)
            w_prod = ~w_prod + (2*W)'(1);
        w_quo = (r_neg1 ^ r_neg2) ? (~w_lo_n + W'(1)) : w_lo_n;
        w_rem = r_neg1 ? (~w_hi_n + W'(1)) : w_hi_n;
        unique case (r_op)
            3'b000:                 w_res = w_prod[W-1:0];
            3'b001, 3'b010, 3'b011: w_res = w_prod[2*W-1:W];
            3'b100, 3'b101:         w_res = w_quo;
            default:                w_res = w_rem;
        endcase
    end

    // Control FSM with registered result, flag and valid pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_op         <= '0;
            r_neg1       <= 1'b0;
            r_neg2       <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            out          <= '0;
            flag         <= 1'b0;
            result_valid <= 1'b0;
        end else if (abort) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            flag         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    result_valid <= 1'b0;
                    flag         <= 1'b0;
                    if (start) begin
                        r_cnt  <= '0;
                        r_op   <= op;
                        r_neg1 <= w_neg1;
                        r_neg2 <= w_neg2;
                        r_a    <= w_mag1;
                        r_b    <= w_mag2;
                        r_hi   <= '0;
                        r_lo   <= op[2] ? w_mag1 : w_mag2;
                        if (w_dz || w_ovf) begin
                            r_state      <= DONE;
                            out          <= w_byp;
                            flag         <= 1'b1;
                            result_valid <= 1'b1;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_hi <= w_hi_n;
                    r_lo <= w_lo_n;
                    if (r_cnt == CW'(W-1)) begin
                        r_state      <= DONE;
                        r_cnt        <= '0;
                        out          <= w_res;
                        result_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    flag         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ready = (r_state == IDLE);
    assign busy  = (r_state == CALC) || (r_state == DONE);

endmodule
